dghv_decrypt: RTL and testbench

Bit-serial decryptor for the integer homomorphic scheme whose secret prime `p` comes from the key generator. It latches `p` when the key generator signals completion. It then accepts ciphertexts `c = p*q + 2r + m` over a valid/ready handshake and computes `residue = c mod p` with a restoring shift-subtract loop, one ciphertext bit per clock. It returns `m = residue[0]` over a second valid/ready handshake.

---
 rtl/dghv_decrypt_if.sv | 26 ++
 rtl/dghv_decrypt.sv | 101 ++++++++++
 tb/tb_dghv_decrypt.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/dghv_decrypt_if.sv
// Handshake bundle for dghv_decrypt: key load, ciphertext in, plaintext bit out.
interface dghv_decrypt_if #(
  parameter int lambda = 32,
  parameter int CW     = 66
);
  logic              key_valid;
  logic [lambda-1:0] p_key;
  logic              ct_valid;
  logic              ct_ready;
  logic [CW-1:0]     ct_in;
  logic              m_valid;
  logic              m_ready;
  logic              m_bit;
  logic [lambda-1:0] residue;
  logic              busy;

  modport master (
    output key_valid, p_key, ct_valid, ct_in, m_ready,
    input  ct_ready, m_valid, m_bit, residue, busy
  );

  modport slave (
    input  key_valid, p_key, ct_valid, ct_in, m_ready,
    output ct_ready, m_valid, m_bit, residue, busy
  );
endinterface

// File: rtl/dghv_decrypt.sv
// Bit-serial DGHV decryptor: residue = c mod p via restoring shift-subtract,
// one ciphertext bit per clock; plaintext bit is residue[0].
module dghv_decrypt #(
  parameter int lambda = 32,
  parameter int CW     = 66
) (
  input logic          clk,
  input logic          reset,
  dghv_decrypt_if.slave bus
);
  localparam int CNT_W = (CW > 1) ? $clog2(CW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic [lambda-1:0] key_q, key_d;
  logic              key_loaded_q, key_loaded_d;
  logic [CW-1:0]     ct_q, ct_d;
  logic [lambda:0]   rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ct_ready_q, ct_ready_d;
  logic              m_valid_q, m_valid_d;
  logic              busy_q, busy_d;
  logic [lambda:0]   trial;
  logic              accept;

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    key_loaded_d = key_loaded_q;
    ct_d         = ct_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    trial        = {rem_q[lambda-1:0], ct_q[CW-1]};
    accept       = (state_q == IDLE) && ct_ready_q && bus.ct_valid;

    case (state_q)
      IDLE: begin
        // A ciphertext accepted on this edge takes priority over a key update.
        if (accept) begin
          ct_d    = bus.ct_in;
          rem_d   = '0;
          cnt_d   = CNT_W'(CW - 1);
          state_d = RUN;
        end else if (bus.key_valid && (bus.p_key != '0)) begin
          key_d        = bus.p_key;
          key_loaded_d = 1'b1;
        end
      end
      RUN: begin
        rem_d = (trial >= {1'b0, key_q}) ? (trial - {1'b0, key_q}) : trial;
        ct_d  = {ct_q[CW-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.m_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next-state view so they carry no input path.
    ct_ready_d = (state_d == IDLE) && key_loaded_d;
    m_valid_d  = (state_d == DONE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      key_q        <= '0;
      key_loaded_q <= 1'b0;
      ct_q         <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      ct_ready_q   <= 1'b0;
      m_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      key_loaded_q <= key_loaded_d;
      ct_q         <= ct_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      ct_ready_q   <= ct_ready_d;
      m_valid_q    <= m_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.ct_ready = ct_ready_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.busy     = busy_q;
  assign bus.m_bit    = rem_q[0];
  assign bus.residue  = rem_q[lambda-1:0];
endmodule

// File: tb/tb_dghv_decrypt.sv
// Randomized self-checking bench for dghv_decrypt against a plain c % p model.
module tb_dghv_decrypt;
  localparam int LAMBDA = 32;
  localparam int CW     = 66;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dghv_decrypt_if #(.lambda(LAMBDA), .CW(CW)) bus ();

  dghv_decrypt #(.lambda(LAMBDA), .CW(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int totalChecks = 0;
  int badChecks   = 0;
  logic [LAMBDA-1:0] modelKey = '0;
  bit modelKeyLoaded = 1'b0;

  task automatic checkOutput(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LAMBDA-1:0] refResidue(input logic [CW-1:0] c, input logic [LAMBDA-1:0] p);
    logic [CW-1:0] r;
    r = c % {{(CW-LAMBDA){1'b0}}, p};
    return r[LAMBDA-1:0];
  endfunction

  task automatic applyStimulusKey(input logic [LAMBDA-1:0] p);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.p_key     = p;
    @(negedge clk);
    bus.key_valid = 1'b0;
    if (p != '0) begin
      modelKey       = p;
      modelKeyLoaded = 1'b1;
    end
  endtask

  task automatic applyStimulusCt(input logic [CW-1:0] c, output bit ok);
    int waited;
    waited = 0;
    @(negedge clk);
    bus.ct_valid = 1'b1;
    bus.ct_in    = c;
    while (!bus.ct_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.ct_ready) begin
      checkOutput("ct_accept_timeout", bus.ct_ready, 1'b1);
      bus.ct_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.ct_valid = 1'b0;
    ok = 1'b1;
    checkOutput("busy_after_accept", bus.busy, 1'b1);
    checkOutput("ct_ready_in_run", bus.ct_ready, 1'b0);
  endtask

  task automatic checkResult(input string tag, input int expLatency,
                             input logic [LAMBDA-1:0] expRes, input int holdCycles);
    int cycles;
    cycles = 0;
    while (!bus.m_valid && cycles < 300) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!bus.m_valid) begin
      checkOutput({tag, "_timeout"}, bus.m_valid, 1'b1);
      return;
    end
    checkOutput({tag, "_latency"}, cycles, expLatency);
    checkOutput({tag, "_residue"}, bus.residue, expRes);
    checkOutput({tag, "_m_bit"}, bus.m_bit, expRes[0]);
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_hold_valid"}, bus.m_valid, 1'b1);
      checkOutput({tag, "_hold_residue"}, bus.residue, expRes);
      checkOutput({tag, "_hold_ct_ready"}, bus.ct_ready, 1'b0);
    end
    @(negedge clk);
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.m_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, bus.m_valid, 1'b0);
    checkOutput({tag, "_ct_ready_back"}, bus.ct_ready, modelKeyLoaded);
  endtask

  task automatic runDecrypt(input string tag, input logic [CW-1:0] c,
                            input logic [LAMBDA-1:0] expRes, input int holdCycles);
    bit ok;
    applyStimulusCt(c, ok);
    if (ok) checkResult(tag, CW, expRes, holdCycles);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;
    bit anyBad;
    bit sawValid;
    bit sawReady;
    logic [95:0] wide;
    logic [CW-1:0] c;
    logic [LAMBDA-1:0] p;

    reset         = 1'b1;
    bus.key_valid = 1'b0;
    bus.p_key     = '0;
    bus.ct_valid  = 1'b0;
    bus.ct_in     = '0;
    bus.m_ready   = 1'b0;
    #12;
    checkOutput("reset_ct_ready", bus.ct_ready, 1'b0);
    checkOutput("reset_m_valid", bus.m_valid, 1'b0);
    checkOutput("reset_m_bit", bus.m_bit, 1'b0);
    checkOutput("reset_residue", bus.residue, '0);
    checkOutput("reset_busy", bus.busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // No key loaded: offered ciphertext must be ignored
    bus.ct_valid = 1'b1;
    bus.ct_in    = 66'd13011;
    anyBad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      anyBad |= bus.ct_ready | bus.m_valid | bus.busy;
    end
    checkOutput("no_key_idle", anyBad, 1'b0);
    bus.ct_valid = 1'b0;

    applyStimulusKey(32'd13);
    checkOutput("ct_ready_after_key", bus.ct_ready, 1'b1);
    runDecrypt("basic", 66'd13011, 32'd11, 0);

    applyStimulusKey(32'd1000003);
    runDecrypt("big_key", 66'd7000045, 32'd24, 1);

    applyStimulusKey(32'd3);
    runDecrypt("all_ones", {CW{1'b1}}, 32'd0, 0);

    applyStimulusKey(32'd1);
    wide = {$urandom, $urandom, $urandom};
    runDecrypt("p_one", wide[CW-1:0], 32'd0, 0);

    for (int i = 0; i < 10; i++) begin
      p = (i % 2 == 0) ? 32'($urandom_range(2, 1000)) : 32'($urandom);
      if (p == '0) p = 32'd1;
      applyStimulusKey(p);
      wide = {$urandom, $urandom, $urandom};
      c = (i == 0) ? {{(CW-LAMBDA){1'b0}}, p - 32'd1} : wide[CW-1:0];
      runDecrypt("random", c, refResidue(c, modelKey), $urandom_range(0, 3));
    end

    // Key change during RUN must not affect the in-flight ciphertext
    applyStimulusKey(32'd13);
    applyStimulusCt(66'd13011, ok);
    if (ok) begin
      repeat (10) @(posedge clk);
      #1;
      bus.key_valid = 1'b1;
      bus.p_key     = 32'd17;
      checkResult("isolate", CW - 10, refResidue(66'd13011, 32'd13), 10);
      @(negedge clk);
      @(negedge clk);
      bus.key_valid = 1'b0;
      modelKey = 32'd17;
      runDecrypt("new_key", 66'd85007, refResidue(66'd85007, modelKey), 0);
    end

    // Asynchronous reset in the middle of RUN
    applyStimulusCt(66'd13011, ok);
    repeat (30) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("midrst_ct_ready", bus.ct_ready, 1'b0);
    checkOutput("midrst_m_valid", bus.m_valid, 1'b0);
    checkOutput("midrst_busy", bus.busy, 1'b0);
    checkOutput("midrst_m_bit", bus.m_bit, 1'b0);
    checkOutput("midrst_residue", bus.residue, '0);
    @(negedge clk);
    reset = 1'b0;
    modelKeyLoaded = 1'b0;
    bus.ct_valid = 1'b1;
    bus.ct_in    = 66'd13011;
    sawValid = 1'b0;
    sawReady = 1'b0;
    repeat (80) begin
      @(negedge clk);
      sawValid |= bus.m_valid;
      sawReady |= bus.ct_ready;
    end
    checkOutput("midrst_no_result", sawValid, 1'b0);
    checkOutput("midrst_key_cleared", sawReady, 1'b0);
    bus.ct_valid = 1'b0;

    // A zero key is never latched
    applyStimulusKey(32'd13);
    applyStimulusKey(32'd0);
    runDecrypt("zero_key", 66'd13011, 32'd11, 1);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end
endmodule
